// File: rtl/iter_muldiv_unit.sv
// Iterative WIDTH-bit multiply (shift-add) / divide (restoring) engine.
// Define MULDIV_SIGNED_EN for two's complement operands.
module iter_muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic             op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, opb;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl, diff;
  logic             match, start, last, zdiv;

`ifdef MULDIV_SIGNED_EN
  logic                 sa, sb;
  logic [2*WIDTH-1:0]   prod;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign match = (aluop == {1'b1, op});
  assign start = (state == IDLE) && aluop[1];
  assign last  = (cnt == CNT_W'(WIDTH-1));
  assign zdiv  = op && (opb == '0);

  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (aluop[1]) state_nx = RUN;
      RUN: begin
        if (!match)    state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: if (!match) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // one iteration: MUL shifts right through {hi,lo}, DIV shifts left
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shl  = {hi, lo[WIDTH-1]};
    diff = shl - {1'b0, opb};
    if (!op) begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_nx = diff[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = shl[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod   = {hi_nx, lo_nx};
    res_lo = lo_nx;
    res_hi = hi_nx;
    if (!op) begin
      if (sa ^ sb) prod = -prod;
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end else begin
      if (sa ^ sb) res_lo = -lo_nx;
      if (sa)      res_hi = -hi_nx;
    end
`else
    res_lo = lo_nx;
    res_hi = hi_nx;
`endif
    // divide by zero: shifted-out dividend already sits in hi
    if (zdiv) res_lo = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= 1'b0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opb         <= '0;
      result      <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sa          <= 1'b0;
      sb          <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (start) begin
        op  <= aluop[0];
        cnt <= '0;
        hi  <= '0;
        lo  <= aluop[0] ? a_mag : b_mag;
        opb <= aluop[0] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
        sa  <= a[WIDTH-1];
        sb  <= b[WIDTH-1];
`endif
      end else if (state == RUN && match) begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          result      <= res_lo;
          result_hi   <= res_hi;
          div_by_zero <= zdiv;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed cases plus
// random MUL/DIV against an arithmetic reference model.
module tb_iter_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  aluop;
  logic [15:0] a, b;
  logic [15:0] result, result_hi;
  logic        busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_lo, last_hi;

  iter_muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .aluop(aluop),
    .a(a),
    .b(b),
    .result(result),
    .result_hi(result_hi),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic op, input logic [15:0] x, y,
                       output logic [15:0] lo, hi,
                       output logic dz);
`ifdef MULDIV_SIGNED_EN
    int sx, sy, p;
    sx = $signed(x);
    sy = $signed(y);
    dz = 1'b0;
    if (!op) begin
      p  = sx * sy;
      lo = p[15:0];
      hi = p[31:16];
    end else if (y == 0) begin
      lo = 16'hFFFF;
      hi = x;
      dz = 1'b1;
    end else if (sx == -32768 && sy == -1) begin
      lo = 16'h8000;
      hi = 16'h0000;
    end else begin
      p  = sx / sy;
      lo = p[15:0];
      p  = sx % sy;
      hi = p[15:0];
    end
`else
    logic [31:0] p;
    dz = 1'b0;
    if (!op) begin
      p  = {16'h0, x} * {16'h0, y};
      lo = p[15:0];
      hi = p[31:16];
    end else if (y == 0) begin
      lo = 16'hFFFF;
      hi = x;
      dz = 1'b1;
    end else begin
      lo = x / y;
      hi = x % y;
    end
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [15:0] x, y);
    @(negedge clk);
    aluop = {1'b1, op};
    a     = x;
    b     = y;
  endtask

  // from the start edge E0 through done at E0+16
  task automatic finish_op(input string tag, input logic op,
                           input logic [15:0] x, y);
    logic [15:0] elo, ehi;
    logic        edz;
    model(op, x, y, elo, ehi, edz);
    tick();
    chk({tag, ".busy0"}, busy, 1);
    a = 16'($urandom);
    b = 16'($urandom);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".early"}, done, 0);
    end
    tick();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".lo"}, result, elo);
    chk({tag, ".hi"}, result_hi, ehi);
    chk({tag, ".dz"}, div_by_zero, edz);
    last_lo = elo;
    last_hi = ehi;
  endtask

  task automatic hold_release(input string tag);
    tick();
    chk({tag, ".hold"}, done, 1);
    chk({tag, ".holdlo"}, result, last_lo);
    @(negedge clk);
    aluop = 2'b00;
    tick();
    chk({tag, ".rel"}, done, 0);
    chk({tag, ".kept"}, result, last_lo);
    chk({tag, ".kepthi"}, result_hi, last_hi);
  endtask

  task automatic run(input string tag, input logic op,
                     input logic [15:0] x, y);
    drive(op, x, y);
    finish_op(tag, op, x, y);
    hold_release(tag);
  endtask

  initial begin
    logic        op;
    logic [15:0] x, y;
    rst   = 1'b1;
    aluop = 2'b00;
    a     = '0;
    b     = '0;
    last_lo = '0;
    last_hi = '0;
    tick();
    tick();
    chk("rst.result", result, 0);
    chk("rst.hi", result_hi, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.dz", div_by_zero, 0);
    @(negedge clk);
    rst   = 1'b0;
    aluop = 2'b01;
    a     = 16'd9;
    b     = 16'd9;
    tick();
    tick();
    chk("addsub.busy", busy, 0);
    chk("addsub.done", done, 0);

    run("mul3x5", 1'b0, 16'd3, 16'd5);
    run("mulmax", 1'b0, 16'hFFFF, 16'hFFFF);
    run("div100_7", 1'b1, 16'd100, 16'd7);
    run("div5_0", 1'b1, 16'd5, 16'd0);

    // abort mid-run: aluop released after E0+5
    drive(1'b0, 16'd9, 16'd9);
    tick();
    for (int i = 1; i <= 5; i++) tick();
    chk("abort.busy5", busy, 1);
    @(negedge clk);
    aluop = 2'b00;
    tick();
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.kept", result, last_lo);
    chk("abort.kepthi", result_hi, last_hi);
    tick();
    chk("abort.nodone", done, 0);

    // reset during a run at E0+8
    drive(1'b1, 16'd50, 16'd3);
    tick();
    for (int i = 1; i <= 7; i++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rstrun.result", result, 0);
    chk("rstrun.hi", result_hi, 0);
    chk("rstrun.busy", busy, 0);
    chk("rstrun.done", done, 0);
    @(negedge clk);
    rst   = 1'b0;
    aluop = 2'b00;
    tick();

    // direct MUL->DIV change passes through one idle cycle
    drive(1'b0, 16'd12, 16'd11);
    finish_op("chg.mul", 1'b0, 16'd12, 16'd11);
    drive(1'b1, 16'd200, 16'd9);
    tick();
    chk("chg.done", done, 0);
    chk("chg.busy", busy, 0);
    finish_op("chg.div", 1'b1, 16'd200, 16'd9);
    hold_release("chg");

`ifdef MULDIV_SIGNED_EN
    run("smul", 1'b0, 16'hFFFA, 16'd7);
    chk("smul.val", {result_hi, result}, 32'hFFFF_FFD6);
    run("sdiv", 1'b1, 16'hFFF9, 16'd2);
    chk("sdiv.val", {result_hi, result}, 32'hFFFF_FFFD);
    run("sovf", 1'b1, 16'h8000, 16'hFFFF);
    chk("sovf.val", {result_hi, result}, 32'h0000_8000);
    run("sdz", 1'b1, 16'hFFF0, 16'h0000);
`endif

    for (int n = 0; n < 24; n++) begin
      op = 1'($urandom_range(0, 1));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) y = 16'h0000;
      if ($urandom_range(0, 9) == 0) x = 16'h8000;
      if ($urandom_range(0, 9) == 0) y = 16'hFFFF;
      run("rand", op, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
